// File: rtl/mult_byte_port.sv
// mult_byte_port: byte-serial host port for the multiplier core.
// Collects operands A and B little-endian from the host byte stream.
// It then launches one multiplication and measures the core latency.
// Finally it streams the 2*WIDTH-bit product back to the host, LSB first.
module mult_byte_port #(
  parameter int WIDTH = 32,
  parameter int LAT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic [LAT_W-1:0]   latency,
  output logic               busy
);

  localparam int NB    = WIDTH / 8;
  localparam int PB    = 2 * NB;
  localparam int CNT_W = $clog2(PB);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_OP   = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] LAST_PB   = CNT_W'(PB - 1);
  localparam logic [LAT_W-1:0] LAT_ZERO  = LAT_W'(0);
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};
  localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(8'hFF);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]         state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0]   a_r, a_s;
  logic [WIDTH-1:0]   b_r, b_s;
  logic [2*WIDTH-1:0] prod_r, prod_s;
  logic [LAT_W-1:0]   lat_cnt_r, lat_cnt_s;
  logic [LAT_W-1:0]   latency_r, latency_s;
  logic [LAT_W-1:0]   lat_inc_s;
  logic [CNT_W+2:0]   byte_sh_s;
  logic               in_xfer_s;
  logic               out_xfer_s;

  logic               in_ready_r, in_ready_s;
  logic               out_valid_r, out_valid_s;
  logic [7:0]         out_data_r, out_data_s;
  logic               mul_start_r, mul_start_s;
  logic               busy_r, busy_s;

  // Next state, operand assembly, product capture and latency counting
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    a_s        = a_r;
    b_s        = b_r;
    prod_s     = prod_r;
    lat_cnt_s  = lat_cnt_r;
    latency_s  = latency_r;
    in_xfer_s  = in_valid && in_ready_r;
    out_xfer_s = out_valid_r && out_ready;
    byte_sh_s  = {cnt_r, 3'b000};
    if (lat_cnt_r == LAT_MAX) begin
      lat_inc_s = LAT_MAX;
    end else begin
      lat_inc_s = lat_cnt_r + LAT_ONE;
    end
    case (state_r)
      S_LOAD_A: begin
        if (in_xfer_s) begin
          a_s = (a_r & ~(BYTE_MASK << byte_sh_s)) | (WIDTH'(in_data) << byte_sh_s);
          if (cnt_r == LAST_OP) begin
            state_s = S_LOAD_B;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          a_s = a_r;
        end
      end
      S_LOAD_B: begin
        if (in_xfer_s) begin
          b_s = (b_r & ~(BYTE_MASK << byte_sh_s)) | (WIDTH'(in_data) << byte_sh_s);
          if (cnt_r == LAST_OP) begin
            state_s = S_START;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          b_s = b_r;
        end
      end
      S_START: begin
        // A done pulse coincident with the launch is not a completion.
        lat_cnt_s = LAT_ZERO;
        state_s   = S_WAIT;
      end
      S_WAIT: begin
        lat_cnt_s = lat_inc_s;
        if (mul_done) begin
          // lat_inc_s is counter+1, so a done in the first WAIT cycle reports 1.
          prod_s    = mul_p;
          latency_s = lat_inc_s;
          state_s   = S_DRAIN;
          cnt_s     = CNT_ZERO;
        end else begin
          latency_s = latency_r;
        end
      end
      S_DRAIN: begin
        if (out_xfer_s) begin
          if (cnt_r == LAST_PB) begin
            state_s = S_LOAD_A;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = S_LOAD_A;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so every host-visible flag is a flop
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    mul_start_s = 1'b0;
    busy_s      = 1'b1;
    case (state_s)
      S_LOAD_A: begin
        in_ready_s = 1'b1;
        busy_s     = (cnt_s != CNT_ZERO);
      end
      S_LOAD_B: begin
        in_ready_s = 1'b1;
      end
      S_START: begin
        mul_start_s = 1'b1;
      end
      S_WAIT: begin
        busy_s = 1'b1;
      end
      S_DRAIN: begin
        out_valid_s = 1'b1;
        out_data_s  = 8'(prod_s >> {cnt_s, 3'b000});
      end
      default: begin
        busy_s = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_LOAD_A;
      cnt_r       <= CNT_ZERO;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      prod_r      <= {(2*WIDTH){1'b0}};
      lat_cnt_r   <= LAT_ZERO;
      latency_r   <= LAT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      mul_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      a_r         <= a_s;
      b_r         <= b_s;
      prod_r      <= prod_s;
      lat_cnt_r   <= lat_cnt_s;
      latency_r   <= latency_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      mul_start_r <= mul_start_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign mul_a     = a_r;
  assign mul_b     = b_r;
  assign mul_start = mul_start_r;
  assign latency   = latency_r;
  assign busy      = busy_r;

endmodule
